// File: rtl/bcdbin_if.sv
// Handshake bundle between the command parser (master) and the BCD-to-binary
// converter (slave).
interface bcdbin_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin;
  logic                  err;

  modport master (
    output start, bcd,
    input  busy, done, bin, err
  );

  modport slave (
    input  start, bcd,
    output busy, done, bin, err
  );
endinterface

// File: rtl/bcdbin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one result
// bit per clock; constant latency of BIN_W clocks from accepted start to done.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | shifting one bit per clock, BIN_W iterations, then pulse done
module bcdbin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic     clk,
  input  logic     rst,
  bcdbin_if.slave  bus
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               err_i;
  logic               bcd_bad;
  logic               last_iter;

  logic               busy_q;
  logic               done_q;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;

  always_comb begin
    bcd_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd[4*d +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  // After halving, a digit that picked up 8 from its odd upper neighbour
  // should have gained 5 instead, so pull it back by 3.
  always_comb begin
    work_nxt = work >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_nxt[BIN_W + 4*d +: 4] >= 4'd8) begin
        work_nxt[BIN_W + 4*d +: 4] = work_nxt[BIN_W + 4*d +: 4] - 4'd3;
      end
    end
  end

  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      err_i  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bin_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work   <= {bus.bcd, {BIN_W{1'b0}}};
            err_i  <= bcd_bad;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) begin
            bin_q  <= err_i ? '0 : work_nxt[BIN_W-1:0];
            err_q  <= err_i;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bin  = bin_q;
  assign bus.err  = err_q;
endmodule
